// File: rtl/multiword_add_seq.sv
// Wide add/subtract sequencer: iterates one bit_width-wide adder slice
// over num_words operand words, LSW first, carrying between beats.
module multiword_add_seq #(
    parameter int bit_width = 8,
    parameter int num_words = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic                           sub,
    input  logic [bit_width*num_words-1:0] a,
    input  logic [bit_width*num_words-1:0] b,
    output logic                           busy,
    output logic                           done,
    output logic [bit_width*num_words-1:0] s,
    output logic                           cout,
    output logic                           ovf
);

    localparam int w     = bit_width * num_words;
    localparam int idx_w = (num_words > 1) ? $clog2(num_words) : 1;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t state;
    state_t state_next;

    logic [w-1:0]         a_q;
    logic [w-1:0]         b_q;
    logic [w-1:0]         acc;
    logic [w-1:0]         acc_next;
    logic                 sub_q;
    logic                 carry_q;
    logic [idx_w-1:0]     idx_q;
    logic [bit_width-1:0] a_w;
    logic [bit_width-1:0] b_w;
    logic [bit_width:0]   sum;
    logic                 msb_cin;
    logic                 last;

    // One slice; B is inverted for subtract, carry register supplies the +1.
    always_comb begin
        a_w      = a_q[int'(idx_q)*bit_width +: bit_width];
        b_w      = b_q[int'(idx_q)*bit_width +: bit_width] ^ {bit_width{sub_q}};
        sum      = {1'b0, a_w} + {1'b0, b_w} + {{bit_width{1'b0}}, carry_q};
        msb_cin  = a_w[bit_width-1] ^ b_w[bit_width-1] ^ sum[bit_width-1];
        acc_next = acc;
        acc_next[int'(idx_q)*bit_width +: bit_width] = sum[bit_width-1:0];
        last     = (idx_q == idx_w'(num_words - 1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            acc     <= '0;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            s       <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        sub_q   <= sub;
                        carry_q <= sub;
                        idx_q   <= '0;
                    end
                end
                RUN: begin
                    acc     <= acc_next;
                    carry_q <= sum[bit_width];
                    if (last) begin
                        idx_q <= '0;
                        s     <= acc_next;
                        cout  <= sum[bit_width];
                        ovf   <= msb_cin ^ sum[bit_width];
                        done  <= 1'b1;
                    end else begin
                        idx_q <= idx_q + idx_w'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multiword_add_seq.sv
// Self-checking bench for multiword_add_seq (8-bit slice, 4 words)
// against a plain-integer reference model.
module tb_multiword_add_seq;

    localparam int bw = 8;
    localparam int nw = 4;
    localparam int w  = bw * nw;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         sub;
    logic [w-1:0] a;
    logic [w-1:0] b;
    logic         busy;
    logic         done;
    logic [w-1:0] s;
    logic         cout;
    logic         ovf;

    int tests = 0;
    int fails = 0;

    multiword_add_seq #(.bit_width(bw), .num_words(nw)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    // Reference: plain 64-bit integer arithmetic on the whole operands.
    function automatic void model(input logic [w-1:0] ma, input logic [w-1:0] mb,
                                  input logic msub, output logic [w-1:0] ms,
                                  output logic mc, output logic mo);
        longint ua = longint'({32'd0, ma});
        longint ub = longint'({32'd0, mb});
        longint sa = longint'($signed(ma));
        longint sb = longint'($signed(mb));
        longint ur;
        longint sr;
        if (msub) begin
            ur = ua - ub;
            sr = sa - sb;
            mc = (ua >= ub);
        end else begin
            ur = ua + ub;
            sr = sa + sb;
            mc = (ur >= 64'sh1_0000_0000);
        end
        ms = ur[w-1:0];
        mo = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    endfunction

    // Issues one op at a negedge and waits (bounded) for done.
    // lat counts negedges after the start negedge; done edge k+4 -> lat 5.
    task automatic run_op(input logic [w-1:0] ta, input logic [w-1:0] tb_,
                          input logic tsub, output int lat, output int busy_n,
                          output bit s_moved);
        logic [w-1:0] s0;
        start = 1'b1;
        a     = ta;
        b     = tb_;
        sub   = tsub;
        s0    = s;
        @(negedge clk);
        start   = 1'b0;
        a       = $urandom;
        b       = $urandom;
        lat     = 1;
        busy_n  = 0;
        s_moved = 1'b0;
        while (!done && lat < 20) begin
            if (busy) busy_n++;
            if (s !== s0) s_moved = 1'b1;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        int bad = 0;
        rst_n = 1'b0;
        start = 1'b0;
        sub   = 1'b0;
        a     = '0;
        b     = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (busy !== 1'b0 || done !== 1'b0 || s !== '0 || cout !== 1'b0 || ovf !== 1'b0)
                bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL reset_idle: busy=%b done=%b s=%h cout=%b ovf=%b, required all 0 (%0d bad)",
                     busy, done, s, cout, ovf, bad);
        end
    endtask

    task automatic test_carry_wrap();
        int lat, bn;
        bit mv;
        run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, lat, bn, mv);
        tests++;
        if (lat !== 5) begin
            fails++;
            $display("FAIL wrap_latency: got %0d required 5", lat);
        end
        tests++;
        if (bn !== 4) begin
            fails++;
            $display("FAIL wrap_busy_cycles: got %0d required 4", bn);
        end
        tests++;
        if (s !== 32'h0 || cout !== 1'b1 || ovf !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL wrap_result: s=%h cout=%b ovf=%b busy=%b required 00000000 1 0 0",
                     s, cout, ovf, busy);
        end
        tests++;
        if (mv) begin
            fails++;
            $display("FAIL wrap_s_stable: s changed during RUN, required stable");
        end
    endtask

    task automatic test_ovf_sub();
        int lat, bn;
        bit mv;
        run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, lat, bn, mv);
        tests++;
        if (s !== 32'h80000000 || cout !== 1'b0 || ovf !== 1'b1) begin
            fails++;
            $display("FAIL add_ovf: s=%h cout=%b ovf=%b required 80000000 0 1", s, cout, ovf);
        end
        run_op(32'h00000005, 32'h00000007, 1'b1, lat, bn, mv);
        tests++;
        if (s !== 32'hFFFFFFFE || cout !== 1'b0 || ovf !== 1'b0) begin
            fails++;
            $display("FAIL sub_borrow: s=%h cout=%b ovf=%b required fffffffe 0 0", s, cout, ovf);
        end
    endtask

    task automatic test_ignore_start();
        int dones = 0;
        bit got_res = 1'b0;
        start = 1'b1;
        sub   = 1'b0;
        a     = 32'h12345678;
        b     = 32'h11111111;
        @(negedge clk);
        a = 32'hFFFFFFFF;
        b = 32'hFFFFFFFF;
        for (int i = 1; i <= 12; i++) begin
            if (done) begin
                dones++;
                if (s === 32'h23456789 && cout === 1'b0) got_res = 1'b1;
            end
            if (i >= 4) start = 1'b0;
            @(negedge clk);
            a = $urandom;
            b = $urandom;
            sub = $urandom_range(1);
        end
        tests++;
        if (dones !== 1) begin
            fails++;
            $display("FAIL ignore_start_dones: got %0d required 1", dones);
        end
        tests++;
        if (!got_res) begin
            fails++;
            $display("FAIL ignore_start_result: s=%h cout=%b required 23456789 0", s, cout);
        end
    endtask

    task automatic test_mid_reset();
        int lat, bn;
        bit mv;
        int dones = 0;
        start = 1'b1;
        sub   = 1'b0;
        a     = 32'hDEADBEEF;
        b     = 32'h01020304;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tests++;
        if (busy !== 1'b0 || s !== '0 || cout !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset_clear: busy=%b s=%h cout=%b done=%b required 0 0 0 0",
                     busy, s, cout, done);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        tests++;
        if (dones !== 0) begin
            fails++;
            $display("FAIL mid_reset_no_done: got %0d dones required 0", dones);
        end
        run_op(32'h000000FF, 32'h00000001, 1'b0, lat, bn, mv);
        tests++;
        if (s !== 32'h00000100 || lat !== 5) begin
            fails++;
            $display("FAIL post_reset_op: s=%h lat=%0d required 00000100 5", s, lat);
        end
    endtask

    task automatic test_back_to_back();
        int lat, bn, gap;
        bit mv;
        bit unstable = 1'b0;
        logic [w-1:0] e1, e2;
        logic c1, c2, o1, o2;
        logic [w-1:0] a2 = $urandom;
        logic [w-1:0] b2 = $urandom;
        model(32'hCAFEF00D, 32'h13579BDF, 1'b0, e1, c1, o1);
        model(a2, b2, 1'b1, e2, c2, o2);
        run_op(32'hCAFEF00D, 32'h13579BDF, 1'b0, lat, bn, mv);
        tests++;
        if (done !== 1'b1 || s !== e1) begin
            fails++;
            $display("FAIL b2b_first: done=%b s=%h required 1 %h", done, s, e1);
        end
        start = 1'b1;
        a     = a2;
        b     = b2;
        sub   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        gap   = 1;
        while (!done && gap < 20) begin
            if (s !== e1) unstable = 1'b1;
            @(negedge clk);
            gap++;
        end
        tests++;
        if (gap !== 5) begin
            fails++;
            $display("FAIL b2b_gap: got %0d cycles required 5", gap);
        end
        tests++;
        if (unstable) begin
            fails++;
            $display("FAIL b2b_first_stable: first result changed before second done");
        end
        tests++;
        if (s !== e2 || cout !== c2 || ovf !== o2) begin
            fails++;
            $display("FAIL b2b_second: s=%h cout=%b ovf=%b required %h %b %b",
                     s, cout, ovf, e2, c2, o2);
        end
    endtask

    task automatic test_random();
        int lat, bn;
        bit mv;
        logic [w-1:0] ra, rb, es;
        logic rs, ec, eo;
        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom_range(1));
            if (i % 8 == 0) rb = ra;
            if (i % 8 == 1) ra = 32'h80000000;
            model(ra, rb, rs, es, ec, eo);
            run_op(ra, rb, rs, lat, bn, mv);
            tests++;
            if (s !== es || cout !== ec || ovf !== eo || lat !== 5 || bn !== 4) begin
                fails++;
                $display("FAIL rand_%0d: a=%h b=%h sub=%b got s=%h c=%b o=%b lat=%0d busy=%0d required %h %b %b 5 4",
                         i, ra, rb, rs, s, cout, ovf, lat, bn, es, ec, eo);
            end
            if (i % 3 == 0) @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_carry_wrap();
        test_ovf_sub();
        test_ignore_start();
        test_mid_reset();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/multiword_add_seq.md
# multiword_add_seq

Sequencing controller that performs wide (bit_width × num_words) add/subtract by iterating one bit_width-wide full-adder slice over the operand words, LSW first, with a registered carry between beats. It sits between a requester (start/done handshake) and the shared word-wide adder datapath, so wide arithmetic reuses one narrow carry chain instead of a full-width one.

## Interface
- bit_width, 8, width of one adder slice (bits per word)
- num_words, 4, number of words per operand; ≥ 1
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- start  input  1  request pulse; sampled only when busy=0
- sub  input  1  0: s = a + b; 1: s = a − b; sampled with start
- a  input  bit_width*num_words  operand A; sampled with start
- b  input  bit_width*num_words  operand B; sampled with start
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse: s/cout/ovf valid
- s  output  bit_width*num_words  result; holds until next completion
- cout  output  1  final carry (sub: 1 = no borrow)
- ovf  output  1  two's-complement overflow of the full-width result

## Operation
- Internal slice: bit_width full adders in a ripple chain with carry-in from carry register; operands are word[idx] of latched A and B (B inverted when sub=1).
- State machine: IDLE, RUN.
  - IDLE: busy=0. start=1 → latch a, b, sub; carry reg ← sub; idx ← 0; go RUN.
  - RUN: busy=1. Each cycle: result word[idx] ← slice sum; carry reg ← slice carry-out; idx ← idx+1. When idx = num_words−1: s ← assembled result, cout ← slice carry-out, ovf ← (carry into MSB) XOR (carry out of MSB) of last word, done ← 1, go IDLE.
- start while busy=1: ignored, no effect on the running operation or latched operands.
- Operand inputs may change freely after the start cycle.
- Arithmetic is modulo 2^(bit_width*num_words); no saturation.
- num_words=1: single RUN cycle; same handshake.
- idx width ceil(log2(num_words)), min 1; never exceeds num_words−1.

## Timing
- Reset (rst_n=0 at a rising edge): state IDLE, busy=0, done=0, s=0, cout=0, ovf=0, carry reg=0, idx=0, internal result cleared. Applies mid-operation: current operation discarded, no done.
- start sampled at edge k → busy=1 after edge k; RUN occupies edges k+1 .. k+num_words.
- After edge k+num_words: done=1, busy=0, s/cout/ovf updated (same edge). done=0 after edge k+num_words+1 unless another completion.
- Latency start→done: num_words cycles. Throughput: one operation per num_words+1 cycles (start accepted the cycle done is high).
- s, cout, ovf change only at a done edge or reset; stable otherwise, including during RUN.
- rst_n has priority over start.

## Test plan
(bit_width=8, num_words=4)
- Reset, then idle 5 cycles → busy=0, done=0, s=0x00000000, cout=0, ovf=0 throughout.
- a=0xFFFFFFFF, b=0x00000001, sub=0, start at edge k → done only after edge k+4; s=0x00000000, cout=1, ovf=0; busy high exactly 4 cycles.
- a=0x7FFFFFFF, b=0x00000001, sub=0 → s=0x80000000, cout=0, ovf=1; then a=0x00000005, b=0x00000007, sub=1 → s=0xFFFFFFFE, cout=0 (borrow), ovf=0.
- start with a=0x12345678, b=0x11111111; pulse start with a=0xFFFFFFFF, b=0xFFFFFFFF and change a/b every cycle during busy → single done, s=0x23456789, cout=0.
- Start op, assert rst_n=0 for one edge during RUN (idx=2) → no done; busy=0, s=0, cout=0 immediately after; next start of 0x000000FF+0x00000001 gives s=0x00000100 after 4 cycles.
- Back-to-back: second start asserted in the cycle done=1 → accepted; second done exactly 5 cycles after first done, first result stable until then.
